// File: rtl/wb_port_arbiter.sv
// Round-robin writeback port arbiter: grants up to WB_NUM of FU_NUM pending results per cycle
// and presents them densely on a registered writeback bus one cycle later.
module wb_port_arbiter #(
    parameter int FU_NUM = 6,
    parameter int WB_NUM = 4,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(FU_NUM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [FU_NUM-1:0]          fu_valid,
    input  logic [FU_NUM*DATA_W-1:0]   fu_data,
    output logic [FU_NUM-1:0]          fu_ready,
    output logic [WB_NUM-1:0]          wb_valid,
    output logic [WB_NUM*DATA_W-1:0]   wb_data,
    output logic [WB_NUM*PTR_W-1:0]    wb_src,
    output logic [PTR_W-1:0]           rr_ptr
);

    localparam logic [PTR_W:0]   FU_NUM_W = (PTR_W+1)'(FU_NUM);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FU_NUM - 1);

    logic                  enable_s;
    logic [PTR_W:0]        sum_s;
    logic [PTR_W-1:0]      src_s;
    int                    cnt_s;
    logic [FU_NUM-1:0]     grant_s;
    logic [WB_NUM-1:0]     port_valid_s;
    logic [PTR_W-1:0]      port_src_s  [WB_NUM];
    logic [DATA_W-1:0]     port_data_s [WB_NUM];
    logic [PTR_W-1:0]      last_s;
    logic                  any_s;
    logic [PTR_W-1:0]      next_ptr_s;

    logic [WB_NUM-1:0]        wb_valid_r;
    logic [WB_NUM*DATA_W-1:0] wb_data_r;
    logic [WB_NUM*PTR_W-1:0]  wb_src_r;
    logic [PTR_W-1:0]         rr_ptr_r;

    // Walk sources in rotating priority order, handing the first WB_NUM valid ones to ports 0..WB_NUM-1
    always_comb begin
        enable_s     = rst & ~flush;
        sum_s        = '0;
        src_s        = '0;
        cnt_s        = 0;
        grant_s      = '0;
        port_valid_s = '0;
        last_s       = rr_ptr_r;
        any_s        = 1'b0;
        for (int j = 0; j < WB_NUM; j++) begin
            port_src_s[j] = '0;
        end
        for (int k = 0; k < FU_NUM; k++) begin
            // Modulo FU_NUM wrap; FU_NUM need not be a power of two
            sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
            if (sum_s >= FU_NUM_W) begin
                src_s = PTR_W'(sum_s - FU_NUM_W);
            end else begin
                src_s = PTR_W'(sum_s);
            end
            if (enable_s && fu_valid[src_s] && (cnt_s < WB_NUM)) begin
                grant_s[src_s] = 1'b1;
                for (int j = 0; j < WB_NUM; j++) begin
                    if (cnt_s == j) begin
                        port_valid_s[j] = 1'b1;
                        port_src_s[j]   = src_s;
                    end else begin
                        port_valid_s[j] = port_valid_s[j];
                    end
                end
                last_s = src_s;
                any_s  = 1'b1;
                cnt_s  = cnt_s + 1;
            end else begin
                cnt_s = cnt_s;
            end
        end
        if (last_s == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = last_s + PTR_W'(1);
        end
    end

    // Payload mux: each port picks the result of the source it was assigned
    always_comb begin
        for (int j = 0; j < WB_NUM; j++) begin
            port_data_s[j] = '0;
            for (int i = 0; i < FU_NUM; i++) begin
                if (port_src_s[j] == PTR_W'(i)) begin
                    port_data_s[j] = fu_data[i*DATA_W +: DATA_W];
                end else begin
                    port_data_s[j] = port_data_s[j];
                end
            end
        end
    end

    // Writeback bus and fairness pointer; flush beats any grant and restarts priority at source 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_r <= '0;
            wb_data_r  <= '0;
            wb_src_r   <= '0;
            rr_ptr_r   <= '0;
        end else if (flush) begin
            wb_valid_r <= '0;
            rr_ptr_r   <= '0;
        end else begin
            wb_valid_r <= port_valid_s;
            for (int j = 0; j < WB_NUM; j++) begin
                if (port_valid_s[j]) begin
                    wb_data_r[j*DATA_W +: DATA_W] <= port_data_s[j];
                    wb_src_r[j*PTR_W +: PTR_W]    <= port_src_s[j];
                end
            end
            if (any_s) begin
                rr_ptr_r <= next_ptr_s;
            end
        end
    end

    assign fu_ready = grant_s;
    assign wb_valid = wb_valid_r;
    assign wb_data  = wb_data_r;
    assign wb_src   = wb_src_r;
    assign rr_ptr   = rr_ptr_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed grants, port order, payloads, flush and reset.
module tb_wb_port_arbiter;

    localparam int FU_NUM = 6;
    localparam int WB_NUM = 4;
    localparam int DATA_W = 64;
    localparam int PTR_W  = 3;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [FU_NUM-1:0]         fu_valid;
    logic [FU_NUM*DATA_W-1:0]  fu_data;
    logic [FU_NUM-1:0]         fu_ready;
    logic [WB_NUM-1:0]         wb_valid;
    logic [WB_NUM*DATA_W-1:0]  wb_data;
    logic [WB_NUM*PTR_W-1:0]   wb_src;
    logic [PTR_W-1:0]          rr_ptr;

    int checks = 0;
    int errors = 0;
    int gcnt [FU_NUM];

    wb_port_arbiter #(.FU_NUM(FU_NUM), .WB_NUM(WB_NUM), .DATA_W(DATA_W), .PTR_W(PTR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .fu_valid (fu_valid),
        .fu_data  (fu_data),
        .fu_ready (fu_ready),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_src   (wb_src),
        .rr_ptr   (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pd(input int s3, input int s2, input int s1, input int s0);
        logic [255:0] r;
        r = '0;
        r[0   +: 64] = 64'hA0 + 64'(s0);
        r[64  +: 64] = 64'hA0 + 64'(s1);
        r[128 +: 64] = 64'hA0 + 64'(s2);
        r[192 +: 64] = 64'hA0 + 64'(s3);
        return r;
    endfunction

    function automatic logic [11:0] ps(input int s3, input int s2, input int s1, input int s0);
        return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tally();
        for (int i = 0; i < FU_NUM; i++) begin
            gcnt[i] = gcnt[i] + int'(fu_ready[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < FU_NUM; i++) begin
            fu_data[i*DATA_W +: DATA_W] = 64'hA0 + 64'(i);
            gcnt[i] = 0;
        end
        rst      = 1'b0;
        flush    = 1'b0;
        fu_valid = 6'b111111;
        step();
        step();
        chk("reset_ready",  256'(fu_ready), 256'(6'b000000));
        chk("reset_valid",  256'(wb_valid), 256'(4'b0000));
        chk("reset_ptr",    256'(rr_ptr),   256'(3'd0));
        chk("reset_src",    256'(wb_src),   256'(12'd0));
        chk("reset_data",   wb_data,        256'd0);

        rst = 1'b1;
        #1;
        chk("first_ready", 256'(fu_ready), 256'(6'b001111));
        tally();
        step();
        chk("first_valid", 256'(wb_valid), 256'(4'b1111));
        chk("first_src",   256'(wb_src),   256'(ps(3, 2, 1, 0)));
        chk("first_data",  wb_data,        pd(3, 2, 1, 0));
        chk("first_ptr",   256'(rr_ptr),   256'(3'd4));
        #1;
        chk("wrap_ready",  256'(fu_ready), 256'(6'b110011));
        tally();
        step();
        chk("wrap_src",    256'(wb_src),   256'(ps(1, 0, 5, 4)));
        chk("wrap_data",   wb_data,        pd(1, 0, 5, 4));
        chk("wrap_ptr",    256'(rr_ptr),   256'(3'd2));
        #1;
        chk("third_ready", 256'(fu_ready), 256'(6'b111100));
        tally();
        step();
        chk("third_src",   256'(wb_src),   256'(ps(5, 4, 3, 2)));
        chk("third_ptr",   256'(rr_ptr),   256'(3'd0));
        for (int i = 0; i < FU_NUM; i++) begin
            chk($sformatf("fair_src%0d", i), 256'(gcnt[i]), 256'(2));
        end

        fu_valid = 6'b100100;
        #1;
        chk("sparse_ready", 256'(fu_ready), 256'(6'b100100));
        step();
        chk("sparse_valid", 256'(wb_valid),    256'(4'b0011));
        chk("sparse_src",   256'(wb_src[5:0]), 256'({3'd5, 3'd2}));
        chk("sparse_data",  256'(wb_data[127:0]), 256'({64'hA5, 64'hA2}));
        chk("sparse_ptr",   256'(rr_ptr),      256'(3'd0));

        fu_valid = 6'b000100;
        #1;
        step();
        chk("single_valid", 256'(wb_valid), 256'(4'b0001));
        chk("single_ptr",   256'(rr_ptr),   256'(3'd3));
        fu_valid = 6'b111111;
        flush    = 1'b1;
        #1;
        chk("flush_ready",      256'(fu_ready), 256'(6'b000000));
        chk("flush_old_valid",  256'(wb_valid), 256'(4'b0001));
        step();
        chk("flush_valid", 256'(wb_valid), 256'(4'b0000));
        chk("flush_ptr",   256'(rr_ptr),   256'(3'd0));
        flush = 1'b0;
        #1;
        chk("resume_ready", 256'(fu_ready), 256'(6'b001111));
        step();
        chk("resume_src",   256'(wb_src),   256'(ps(3, 2, 1, 0)));
        chk("resume_ptr",   256'(rr_ptr),   256'(3'd4));
        step();
        chk("resume2_ptr",  256'(rr_ptr),   256'(3'd2));

        fu_valid = 6'b000000;
        #1;
        chk("squash_ready", 256'(fu_ready), 256'(6'b000000));
        step();
        chk("idle_valid",   256'(wb_valid), 256'(4'b0000));
        chk("idle_ptr",     256'(rr_ptr),   256'(3'd2));
        fu_valid = 6'b000001;
        #1;
        chk("late_ready",   256'(fu_ready), 256'(6'b000001));
        step();
        chk("late_valid",   256'(wb_valid),    256'(4'b0001));
        chk("late_src",     256'(wb_src[2:0]), 256'(3'd0));
        chk("late_data",    256'(wb_data[63:0]), 256'(64'hA0));
        chk("late_ptr",     256'(rr_ptr),      256'(3'd1));

        fu_valid = 6'b111111;
        #1;
        chk("ptr1_ready", 256'(fu_ready), 256'(6'b011110));
        #2;
        rst = 1'b0;
        #1;
        chk("async_ready", 256'(fu_ready), 256'(6'b000000));
        chk("async_valid", 256'(wb_valid), 256'(4'b0000));
        chk("async_ptr",   256'(rr_ptr),   256'(3'd0));
        chk("async_src",   256'(wb_src),   256'(12'd0));
        step();
        rst = 1'b1;
        #1;
        chk("rerel_ready", 256'(fu_ready), 256'(6'b001111));
        step();
        chk("rerel_src",   256'(wb_src),   256'(ps(3, 2, 1, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
